// File: rtl/l2_i_responder.sv
// L2 responder for L1 I-cache line reads: 2-way set-associative tag lookup,
// fixed-latency hit answer, memory fetch and tag refill on a miss.
module l2_i_responder #(
   parameter int TNUM_2  = 18,
   parameter int INUM_2  = 8,
   parameter int HIT_LAT = 2
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic              read_L1_L2,
   input  logic [INUM_2-1:0] index_L1_L2,
   input  logic [TNUM_2-1:0] tag_L1_L2,
   input  logic              flush,
   input  logic              ready_MEM_L2,
   output logic              ready_L2_L1,
   output logic              read_L2_MEM,
   output logic [INUM_2-1:0] index_L2_MEM,
   output logic [TNUM_2-1:0] tag_L2_MEM,
   output logic              way_L2,
   output logic              refill_L2,
   output logic              busy
);

   localparam int NSETS = 1 << INUM_2;
   localparam int CW    = (HIT_LAT < 2) ? 1 : $clog2(HIT_LAT);

   localparam logic [3:0] S_IDLE     = 4'd0;
   localparam logic [3:0] S_FLUSH    = 4'd1;
   localparam logic [3:0] S_TAG_RD   = 4'd2;
   localparam logic [3:0] S_LOOKUP   = 4'd3;
   localparam logic [3:0] S_HIT_WAIT = 4'd4;
   localparam logic [3:0] S_MISS_REQ = 4'd5;
   localparam logic [3:0] S_REFILL   = 4'd6;
   localparam logic [3:0] S_RESP     = 4'd7;
   localparam logic [3:0] S_GAP      = 4'd8;

   logic [3:0]        r_state;
   logic [3:0]        w_state_next;
   logic [INUM_2-1:0] r_index;
   logic [TNUM_2-1:0] r_tag;
   logic              r_way;
   logic              r_pend;
   logic [CW-1:0]     r_cnt;
   logic [NSETS-1:0]  r_lru;

   logic [1:0]        w_vld;
   logic [1:0]        w_match;
   logic              w_hit;
   logic              w_hit_way;
   logic              w_victim;
   logic              w_flush_req;

   // Per-way tag store: valid bits in flops (cleared in one cycle), tags in RAM
   // with a registered read that is launched while in S_TAG_RD.
   for (genvar gi = 0; gi < 2; gi++) begin : g_way
      logic [NSETS-1:0]  r_valid;
      logic [TNUM_2-1:0] r_mem [NSETS];
      logic [TNUM_2-1:0] r_rd;
      logic              w_wr;

      assign w_wr = (r_state == S_REFILL) && (r_way == 1'(gi));

      always_ff @(posedge clk or negedge nrst) begin
         if (!nrst) begin
            r_valid <= '0;
         end else if (r_state == S_FLUSH) begin
            r_valid <= '0;
         end else if (w_wr) begin
            r_valid[r_index] <= 1'b1;
         end
      end

      always_ff @(posedge clk) begin
         if (w_wr) begin
            r_mem[r_index] <= r_tag;
         end
         r_rd <= r_mem[r_index];
      end

      assign w_vld[gi]   = r_valid[r_index];
      assign w_match[gi] = r_valid[r_index] && (r_rd == r_tag);
   end

   assign w_hit       = |w_match;
   assign w_hit_way   = ~w_match[0];
   assign w_victim    = !w_vld[0] ? 1'b0 : (!w_vld[1] ? 1'b1 : r_lru[r_index]);
   assign w_flush_req = flush || r_pend;

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_flush_req) begin
               w_state_next = S_FLUSH;
            end else if (read_L1_L2) begin
               w_state_next = S_TAG_RD;
            end
         end
         S_FLUSH:    w_state_next = S_IDLE;
         S_TAG_RD:   w_state_next = S_LOOKUP;
         S_LOOKUP:   w_state_next = w_hit ? S_HIT_WAIT : S_MISS_REQ;
         S_HIT_WAIT: begin
            if (r_cnt == CW'(HIT_LAT - 1)) begin
               w_state_next = S_RESP;
            end
         end
         S_MISS_REQ: begin
            if (ready_MEM_L2) begin
               w_state_next = S_REFILL;
            end
         end
         S_REFILL:   w_state_next = S_RESP;
         S_RESP:     w_state_next = S_GAP;
         S_GAP:      w_state_next = S_IDLE;
         default:    w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_state <= S_IDLE;
         r_index <= '0;
         r_tag   <= '0;
         r_way   <= 1'b0;
         r_pend  <= 1'b0;
         r_cnt   <= '0;
         r_lru   <= '0;
      end else begin
         r_state <= w_state_next;
         // A flush seen mid-transaction is remembered and run from the next IDLE.
         if (r_state == S_FLUSH) begin
            r_pend <= 1'b0;
         end else if (flush && (r_state != S_IDLE)) begin
            r_pend <= 1'b1;
         end
         case (r_state)
            S_IDLE: begin
               if (!w_flush_req && read_L1_L2) begin
                  r_index <= index_L1_L2;
                  r_tag   <= tag_L1_L2;
               end
            end
            S_FLUSH: r_lru <= '0;
            S_LOOKUP: begin
               r_cnt <= '0;
               if (w_hit) begin
                  r_way          <= w_hit_way;
                  r_lru[r_index] <= ~w_hit_way;
               end else begin
                  r_way <= w_victim;
               end
            end
            S_HIT_WAIT: r_cnt <= r_cnt + 1'b1;
            S_REFILL:   r_lru[r_index] <= ~r_way;
            default: ;
         endcase
      end
   end

   assign ready_L2_L1  = (r_state == S_RESP);
   assign read_L2_MEM  = (r_state == S_MISS_REQ);
   assign refill_L2    = (r_state == S_REFILL);
   assign busy         = (r_state != S_IDLE);
   assign index_L2_MEM = r_index;
   assign tag_L2_MEM   = r_tag;
   assign way_L2       = r_way;

endmodule

// File: tb/tb_l2_i_responder.sv
// Directed bench for l2_i_responder: a transaction-level cache model schedules
// the expected output waveform per cycle; one negedge process compares it.
module tb_l2_i_responder;

   localparam int TN   = 18;
   localparam int IN   = 8;
   localparam int HL   = 2;
   localparam int NCYC = 1024;

   logic          clk = 1'b0;
   logic          nrst = 1'b0;
   logic          read_L1_L2 = 1'b0;
   logic [IN-1:0] index_L1_L2 = '0;
   logic [TN-1:0] tag_L1_L2 = '0;
   logic          flush = 1'b0;
   logic          ready_MEM_L2 = 1'b0;
   logic          ready_L2_L1;
   logic          read_L2_MEM;
   logic [IN-1:0] index_L2_MEM;
   logic [TN-1:0] tag_L2_MEM;
   logic          way_L2;
   logic          refill_L2;
   logic          busy;

   l2_i_responder #(.TNUM_2(TN), .INUM_2(IN), .HIT_LAT(HL)) dut (
      .clk         (clk),
      .nrst        (nrst),
      .read_L1_L2  (read_L1_L2),
      .index_L1_L2 (index_L1_L2),
      .tag_L1_L2   (tag_L1_L2),
      .flush       (flush),
      .ready_MEM_L2(ready_MEM_L2),
      .ready_L2_L1 (ready_L2_L1),
      .read_L2_MEM (read_L2_MEM),
      .index_L2_MEM(index_L2_MEM),
      .tag_L2_MEM  (tag_L2_MEM),
      .way_L2      (way_L2),
      .refill_L2   (refill_L2),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // expected per-cycle outputs (cycle k = the cycle that starts at edge k)
   bit          e_busy   [NCYC];
   bit          e_rmem   [NCYC];
   bit          e_refill [NCYC];
   bit          e_ready  [NCYC];
   bit          e_way    [NCYC];
   bit          e_wdc    [NCYC];
   bit [IN-1:0] e_idx    [NCYC];
   bit [TN-1:0] e_tag    [NCYC];

   // cache model: two ways per set plus the way to evict next
   bit          m_v   [2][256];
   bit [TN-1:0] m_t   [2][256];
   bit          m_lru [256];

   int n_vec = 0;
   int n_err = 0;
   int idle_from = NCYC;
   bit chk_on = 1'b1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (chk_on && cyc < NCYC) begin
         chk("ready_L2_L1", 32'(ready_L2_L1), 32'(e_ready[cyc]));
         chk("read_L2_MEM", 32'(read_L2_MEM), 32'(e_rmem[cyc]));
         chk("refill_L2", 32'(refill_L2), 32'(e_refill[cyc]));
         chk("busy", 32'(busy), 32'(e_busy[cyc]));
         chk("index_L2_MEM", 32'(index_L2_MEM), 32'(e_idx[cyc]));
         chk("tag_L2_MEM", 32'(tag_L2_MEM), 32'(e_tag[cyc]));
         if (!e_wdc[cyc]) chk("way_L2", 32'(way_L2), 32'(e_way[cyc]));
      end
   end

   task automatic m_clear();
      for (int s = 0; s < 256; s++) begin
         m_v[0][s] = 1'b0;
         m_v[1][s] = 1'b0;
         m_lru[s]  = 1'b0;
      end
   endtask

   task automatic m_lookup(input int s, input bit [TN-1:0] t, output bit hit, output bit w);
      if (m_v[0][s] && m_t[0][s] == t) begin
         hit = 1'b1; w = 1'b0;
      end else if (m_v[1][s] && m_t[1][s] == t) begin
         hit = 1'b1; w = 1'b1;
      end else begin
         hit = 1'b0;
         w = !m_v[0][s] ? 1'b0 : (!m_v[1][s] ? 1'b1 : m_lru[s]);
         m_v[w][s] = 1'b1;
         m_t[w][s] = t;
      end
      m_lru[s] = ~w;
   endtask

   task automatic sched_reset(input int c);
      for (int k = c; k < NCYC; k++) begin
         e_busy[k] = 1'b0; e_rmem[k] = 1'b0; e_refill[k] = 1'b0; e_ready[k] = 1'b0;
         e_way[k] = 1'b0; e_wdc[k] = 1'b0; e_idx[k] = '0; e_tag[k] = '0;
      end
   endtask

   // opt: [0] scramble inputs after capture, [1] stray ready_MEM_L2 during a hit,
   //      [2] flush together with the request, [3] flush during MISS_REQ,
   //      [4] reset during MISS_REQ
   task automatic req(input bit [IN-1:0] i, input bit [TN-1:0] t, input bit [4:0] opt,
                      input bit xh, input bit xw);
      int e, f, m, r, stop;
      bit hit, w;
      e = (cyc + 1 > idle_from + 1) ? cyc + 1 : idle_from + 1;
      f = -1;
      read_L1_L2 = 1'b1; index_L1_L2 = i; tag_L1_L2 = t;
      if (opt[2]) begin
         flush = 1'b1; f = e; e_busy[f] = 1'b1; m_clear(); e = f + 2;
      end
      m_lookup(int'(i), t, hit, w);
      chk("model_hit", 32'(hit), 32'(xh));
      chk("model_way", 32'(w), 32'(xw));
      m = e + 5;
      r = hit ? e + HL + 2 : m + 1;
      for (int k = e; k <= r + 1; k++) e_busy[k] = 1'b1;
      for (int k = e; k < NCYC; k++) begin
         e_idx[k] = i; e_tag[k] = t; e_way[k] = w;
      end
      e_wdc[e] = 1'b1; e_wdc[e + 1] = 1'b1;
      if (!hit) begin
         for (int k = e + 2; k < m; k++) e_rmem[k] = 1'b1;
         e_refill[m] = 1'b1;
      end
      e_ready[r] = 1'b1;
      idle_from = r + 2;
      if (opt[3]) begin
         e_busy[r + 3] = 1'b1; idle_from = r + 4;
      end
      stop = opt[4] ? e + 5 : r;
      while (cyc < stop) begin
         @(posedge clk); #1;
         if (cyc == f) flush = 1'b0;
         if (opt[0] && cyc == e) begin
            index_L1_L2 = IN'($urandom); tag_L1_L2 = TN'($urandom);
         end
         if (opt[1] && cyc == e + 2) ready_MEM_L2 = 1'b1;
         if (opt[1] && cyc == e + 3) ready_MEM_L2 = 1'b0;
         if (!hit && !opt[4] && cyc == m - 1) ready_MEM_L2 = 1'b1;
         if (!hit && !opt[4] && cyc == m) ready_MEM_L2 = 1'b0;
         if (opt[3] && cyc == e + 3) flush = 1'b1;
         if (opt[3] && cyc == e + 4) flush = 1'b0;
         if (!opt[4] && cyc == r) read_L1_L2 = 1'b0;
         if (opt[4] && cyc == e + 3) begin
            nrst = 1'b0; read_L1_L2 = 1'b0;
            sched_reset(cyc); m_clear(); idle_from = NCYC;
            #1;
            chk("async_ready", 32'(ready_L2_L1), 32'd0);
            chk("async_rmem", 32'(read_L2_MEM), 32'd0);
            chk("async_refill", 32'(refill_L2), 32'd0);
            chk("async_busy", 32'(busy), 32'd0);
            chk("async_index", 32'(index_L2_MEM), 32'd0);
            chk("async_tag", 32'(tag_L2_MEM), 32'd0);
         end
         if (opt[4] && cyc == e + 5) begin
            nrst = 1'b1; idle_from = cyc;
         end
      end
      if (opt[3]) m_clear();
   endtask

   initial begin
      m_clear();
      @(posedge clk); #1;
      @(posedge clk); #1;
      nrst = 1'b1;
      idle_from = cyc;
      req(8'h05, 18'h12345, 5'b00000, 1'b0, 1'b0);   // cold miss, victim way0
      req(8'h05, 18'h12345, 5'b00011, 1'b1, 1'b0);   // hit, inputs scrambled, stray mem ready
      req(8'h05, 18'h00ABC, 5'b00000, 1'b0, 1'b1);   // fills invalid way1
      req(8'h05, 18'h12345, 5'b00000, 1'b1, 1'b0);   // hit, LRU -> way1
      req(8'h05, 18'h3FFFF, 5'b00000, 1'b0, 1'b1);   // evicts way1
      req(8'h05, 18'h12345, 5'b00000, 1'b1, 1'b0);   // still hits
      req(8'h05, 18'h00ABC, 5'b00000, 1'b0, 1'b1);   // misses again
      req(8'h09, 18'h3FFFF, 5'b00000, 1'b0, 1'b0);   // other set, back-to-back
      req(8'h05, 18'h12345, 5'b00100, 1'b0, 1'b0);   // flush wins over request
      req(8'h05, 18'h00ABC, 5'b01000, 1'b0, 1'b1);   // flush during miss
      req(8'h05, 18'h00ABC, 5'b00000, 1'b0, 1'b0);   // line gone after pending flush
      req(8'h07, 18'h2AAAA, 5'b10000, 1'b0, 1'b0);   // reset mid-miss
      req(8'h07, 18'h2AAAA, 5'b00000, 1'b0, 1'b0);   // misses after reset
      req(8'h07, 18'h2AAAA, 5'b00000, 1'b1, 1'b0);   // then hits
      repeat (6) begin
         @(posedge clk); #1;
      end
      @(negedge clk); #1;
      chk_on = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
